// File: rtl/min_max_active_reducer_pkg.sv
// rtl/min_max_active_reducer_pkg.sv - shared state encoding and mode constants for the min/max reducer
package min_max_active_reducer_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic MODE_MIN = 1'b0;
    localparam logic MODE_MAX = 1'b1;

endpackage

// File: rtl/min_max_compare_step.sv
// rtl/min_max_compare_step.sv - single-element take/keep decision for the min/max reducer
import min_max_active_reducer_pkg::*;

module min_max_compare_step #(
    parameter int NUMBER_SIZE = 4
) (
    input  logic signed [NUMBER_SIZE-1:0] value,
    input  logic                          activation,
    input  logic signed [NUMBER_SIZE-1:0] acc,
    input  logic                          acc_activation,
    input  logic                          mode,
    output logic                          take
);

    logic better;

    // Strict compare so an equal later element never displaces an earlier winner.
    always_comb begin
        better = 1'b0;
        if (mode == MODE_MAX) begin
            better = (value > acc);
        end else begin
            better = (value < acc);
        end
        take = activation && (!acc_activation || better);
    end

endmodule

// File: rtl/min_max_active_reducer.sv
// rtl/min_max_active_reducer.sv - sequential signed min/max over the active elements of a packed vector
import min_max_active_reducer_pkg::*;

module min_max_active_reducer #(
    parameter  int NUMBER_SIZE = 4,
    parameter  int NUM_INPUTS  = 8,
    localparam int INDEX_SIZE  = $clog2(NUM_INPUTS)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic                              mode,
    input  logic [NUM_INPUTS*NUMBER_SIZE-1:0] numbers,
    input  logic [NUM_INPUTS-1:0]             activations,
    output logic                              in_ready,
    output logic [NUMBER_SIZE-1:0]            result,
    output logic                              result_activation,
    output logic [INDEX_SIZE-1:0]             result_index,
    output logic [INDEX_SIZE:0]               active_count,
    output logic                              out_valid,
    input  logic                              out_ready
);

    localparam logic [INDEX_SIZE-1:0] LAST_IDX = INDEX_SIZE'(NUM_INPUTS - 1);
    localparam logic [INDEX_SIZE-1:0] IDX_ONE  = INDEX_SIZE'(1);
    localparam logic [INDEX_SIZE:0]   CNT_ONE  = (INDEX_SIZE + 1)'(1);

    logic [1:0]                        state;
    logic [NUM_INPUTS*NUMBER_SIZE-1:0] numbers_q;
    logic [NUM_INPUTS-1:0]             activations_q;
    logic                              mode_q;
    logic [INDEX_SIZE-1:0]             scan_idx;

    logic signed [NUMBER_SIZE-1:0]     elem;
    logic                              elem_act;
    logic                              take;

    assign elem     = numbers_q[int'(scan_idx)*NUMBER_SIZE +: NUMBER_SIZE];
    assign elem_act = activations_q[scan_idx];

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);

    min_max_compare_step #(
        .NUMBER_SIZE(NUMBER_SIZE)
    ) u_step (
        .value         (elem),
        .activation    (elem_act),
        .acc           ($signed(result)),
        .acc_activation(result_activation),
        .mode          (mode_q),
        .take          (take)
    );

    // The result registers double as the accumulator, so they hold their last
    // values after the acknowledge and are only cleared by reset or a new job.
    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= ST_IDLE;
            numbers_q         <= '0;
            activations_q     <= '0;
            mode_q            <= MODE_MIN;
            scan_idx          <= '0;
            result            <= '0;
            result_activation <= 1'b0;
            result_index      <= '0;
            active_count      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        numbers_q         <= numbers;
                        activations_q     <= activations;
                        mode_q            <= mode;
                        scan_idx          <= '0;
                        result            <= '0;
                        result_activation <= 1'b0;
                        result_index      <= '0;
                        active_count      <= '0;
                        state             <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (elem_act) begin
                        active_count <= active_count + CNT_ONE;
                    end
                    if (take) begin
                        result            <= elem;
                        result_activation <= 1'b1;
                        result_index      <= scan_idx;
                    end
                    if (scan_idx == LAST_IDX) begin
                        state <= ST_DONE;
                    end else begin
                        scan_idx <= scan_idx + IDX_ONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_min_max_active_reducer.sv
// tb/tb_min_max_active_reducer.sv - directed self-checking bench for min_max_active_reducer
module tb_min_max_active_reducer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        mode;
    logic [15:0] numbers;
    logic [3:0]  activations;
    logic        in_ready;
    logic [3:0]  result;
    logic        result_activation;
    logic [1:0]  result_index;
    logic [2:0]  active_count;
    logic        out_valid;
    logic        out_ready;

    int pass_cnt = 0;
    int total    = 0;

    always #5 clk = ~clk;

    min_max_active_reducer #(
        .NUMBER_SIZE(4),
        .NUM_INPUTS (4)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .mode             (mode),
        .numbers          (numbers),
        .activations      (activations),
        .in_ready         (in_ready),
        .result           (result),
        .result_activation(result_activation),
        .result_index     (result_index),
        .active_count     (active_count),
        .out_valid        (out_valid),
        .out_ready        (out_ready)
    );

    // Accepts a job, scrambles the inputs right after the accept edge, and
    // returns how many edges after the accept edge out_valid appeared.
    task automatic run_job(input logic [15:0] nums, input logic [3:0] acts,
                           input logic md, output int lat);
        @(negedge clk);
        numbers     = nums;
        activations = acts;
        mode        = md;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start       = 1'b0;
        numbers     = 16'h7F7F;
        activations = ~acts;
        mode        = ~md;
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic ack_result();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        total++;
        if ({in_ready, out_valid, result, result_activation, result_index, active_count} !== {1'b1, 1'b0, 4'h0, 1'b0, 2'd0, 3'd0})
            $display("FAIL reset_state: got rdy=%b vld=%b res=%h act=%b idx=%0d cnt=%0d, want rdy=1 vld=0 zeros",
                     in_ready, out_valid, result, result_activation, result_index, active_count);
        else pass_cnt++;
    endtask

    task automatic test_max_all();
        int lat;
        run_job(16'h85E3, 4'b1111, 1'b1, lat);
        total++;
        if (lat !== 4) $display("FAIL max_all_latency: got %0d want 4", lat);
        else pass_cnt++;
        total++;
        if ({result, result_index, result_activation, active_count, in_ready} !== {4'd5, 2'd2, 1'b1, 3'd4, 1'b0})
            $display("FAIL max_all: got res=%h idx=%0d act=%b cnt=%0d rdy=%b want 5 2 1 4 0",
                     result, result_index, result_activation, active_count, in_ready);
        else pass_cnt++;
        ack_result();
        total++;
        if ({out_valid, in_ready, result} !== {1'b0, 1'b1, 4'd5})
            $display("FAIL max_all_ack: got vld=%b rdy=%b res=%h want 0 1 5", out_valid, in_ready, result);
        else pass_cnt++;
    endtask

    task automatic test_min_all();
        int lat;
        run_job(16'h85E3, 4'b1111, 1'b0, lat);
        total++;
        if ({result, result_index, active_count} !== {4'h8, 2'd3, 3'd4})
            $display("FAIL min_all: got res=%h idx=%0d cnt=%0d want 8 3 4", result, result_index, active_count);
        else pass_cnt++;
        ack_result();
    endtask

    task automatic test_min_partial();
        int lat;
        run_job(16'h85E3, 4'b0111, 1'b0, lat);
        total++;
        if ({result, result_index, result_activation, active_count} !== {4'hE, 2'd1, 1'b1, 3'd3})
            $display("FAIL min_partial: got res=%h idx=%0d act=%b cnt=%0d want e 1 1 3",
                     result, result_index, result_activation, active_count);
        else pass_cnt++;
        ack_result();
    endtask

    task automatic test_tie();
        int lat;
        run_job(16'h1772, 4'b1111, 1'b1, lat);
        total++;
        if ({result, result_index} !== {4'd7, 2'd1})
            $display("FAIL tie_lower_index: got res=%h idx=%0d want 7 1", result, result_index);
        else pass_cnt++;
        ack_result();
    endtask

    task automatic test_none_active();
        int lat;
        run_job(16'h85E3, 4'b0000, 1'b1, lat);
        total++;
        if ({out_valid, result, result_activation, result_index, active_count} !== {1'b1, 4'h0, 1'b0, 2'd0, 3'd0})
            $display("FAIL none_active: got vld=%b res=%h act=%b idx=%0d cnt=%0d want 1 0 0 0 0",
                     out_valid, result, result_activation, result_index, active_count);
        else pass_cnt++;
        total++;
        if (lat !== 4) $display("FAIL none_active_latency: got %0d want 4", lat);
        else pass_cnt++;
        ack_result();
    endtask

    task automatic test_backpressure();
        int lat;
        int bad;
        run_job(16'h85E3, 4'b1111, 1'b1, lat);
        bad = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            out_ready   = 1'b0;
            start       = 1'b1;
            numbers     = 16'h1111;
            activations = 4'b1111;
            mode        = 1'b0;
            @(posedge clk);
            #1;
            if ({out_valid, in_ready, result, result_index, active_count} !== {1'b1, 1'b0, 4'd5, 2'd2, 3'd4}) bad++;
        end
        total++;
        if (bad !== 0) $display("FAIL hold_stable: got %0d unstable cycles want 0", bad);
        else pass_cnt++;
        @(negedge clk);
        out_ready = 1'b1;
        start     = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        total++;
        if ({out_valid, in_ready, result, result_index} !== {1'b0, 1'b1, 4'd5, 2'd2})
            $display("FAIL ack_with_start: got vld=%b rdy=%b res=%h idx=%0d want 0 1 5 2",
                     out_valid, in_ready, result, result_index);
        else pass_cnt++;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if ({in_ready, result} !== {1'b1, 4'd5})
            $display("FAIL start_ignored_on_ack: got rdy=%b res=%h want 1 5", in_ready, result);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_scan();
        int lat;
        @(negedge clk);
        numbers     = 16'h85E3;
        activations = 4'b1111;
        mode        = 1'b1;
        start       = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        total++;
        if ({in_ready, out_valid, result, result_activation, result_index, active_count} !== {1'b1, 1'b0, 4'h0, 1'b0, 2'd0, 3'd0})
            $display("FAIL reset_mid_scan: got rdy=%b vld=%b res=%h act=%b idx=%0d cnt=%0d want 1 0 zeros",
                     in_ready, out_valid, result, result_activation, result_index, active_count);
        else pass_cnt++;
        run_job(16'h1772, 4'b1111, 1'b0, lat);
        total++;
        if ({lat[2:0], result, result_index, active_count} !== {3'd4, 4'd1, 2'd3, 3'd4})
            $display("FAIL job_after_reset: got lat=%0d res=%h idx=%0d cnt=%0d want 4 1 3 4",
                     lat, result, result_index, active_count);
        else pass_cnt++;
        ack_result();
    endtask

    task automatic test_back_to_back();
        int lat;
        run_job(16'h85E3, 4'b1010, 1'b1, lat);
        total++;
        if ({result, result_index, active_count} !== {4'hE, 2'd1, 3'd2})
            $display("FAIL b2b_first: got res=%h idx=%0d cnt=%0d want e 1 2", result, result_index, active_count);
        else pass_cnt++;
        ack_result();
        run_job(16'h85E3, 4'b1010, 1'b0, lat);
        total++;
        if ({lat[2:0], result, result_index, active_count} !== {3'd4, 4'h8, 2'd3, 3'd2})
            $display("FAIL b2b_second: got lat=%0d res=%h idx=%0d cnt=%0d want 4 8 3 2",
                     lat, result, result_index, active_count);
        else pass_cnt++;
        ack_result();
    endtask

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        mode        = 1'b0;
        numbers     = '0;
        activations = '0;
        out_ready   = 1'b0;
        test_reset();
        test_max_all();
        test_min_all();
        test_min_partial();
        test_tie();
        test_none_active();
        test_backpressure();
        test_reset_mid_scan();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
